// File: rtl/rope_line_renderer_pkg.sv
// Shared definitions for the rope line renderer and the rope controller:
// screen geometry, colour width, default pivots and the renderer FSM encoding.
package rope_line_renderer_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COL_W    = 3;
    localparam int COORD_W  = 12;

    localparam logic [9:0] DEFAULT_ORIGIN_X = 10'd160;
    localparam logic [9:0] DEFAULT_ORIGIN_Y = 10'd45;
    localparam logic [9:0] P1_ORIGIN_X      = 10'd77;
    localparam logic [9:0] P2_ORIGIN_X      = 10'd237;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INIT_ERASE = 3'd1,
        ST_ERASE      = 3'd2,
        ST_INIT_DRAW  = 3'd3,
        ST_DRAW       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    function automatic logic on_screen(input coord_t x, input coord_t y);
        on_screen = (x >= 12'sd0) && (x < 12'sd320) && (y >= 12'sd0) && (y < 12'sd240);
    endfunction

endpackage

// File: rtl/rope_line_stepper.sv
// Bresenham line stepper: load captures a segment, each step advances one pixel;
// last flags the endpoint pixel, after which valid drops.
module rope_line_stepper
    import rope_line_renderer_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  logic   step,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output coord_t cur_x,
    output coord_t cur_y,
    output logic   valid,
    output logic   last
);

    coord_t x_r, y_r, x1_r, y1_r, err_r, dx_r, dy_r;
    logic   sx_neg_r, sy_neg_r, valid_r;

    coord_t dx_ld_s, dy_ld_s;
    coord_t x_nxt_s, y_nxt_s, err_nxt_s;
    logic signed [COORD_W:0] e2_s, dx_ext_s, dy_ext_s;
    logic   last_s;

    // Segment setup values and the next pixel of the current segment.
    always_comb begin
        dx_ld_s   = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        dy_ld_s   = (y1 >= y0) ? (y0 - y1) : (y1 - y0);
        e2_s      = {err_r, 1'b0};
        dx_ext_s  = {dx_r[COORD_W-1], dx_r};
        dy_ext_s  = {dy_r[COORD_W-1], dy_r};
        err_nxt_s = err_r;
        x_nxt_s   = x_r;
        y_nxt_s   = y_r;
        if (e2_s >= dy_ext_s) begin
            err_nxt_s = err_nxt_s + dy_r;
            x_nxt_s   = sx_neg_r ? (x_r - 12'sd1) : (x_r + 12'sd1);
        end else begin
            x_nxt_s   = x_r;
        end
        // Both tests use the e2 taken before either update.
        if (e2_s <= dx_ext_s) begin
            err_nxt_s = err_nxt_s + dx_r;
            y_nxt_s   = sy_neg_r ? (y_r - 12'sd1) : (y_r + 12'sd1);
        end else begin
            y_nxt_s   = y_r;
        end
        last_s = valid_r && (x_r == x1_r) && (y_r == y1_r);
    end

    // Stepper state: load a new segment or advance one pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_r      <= 12'sd0;
            y_r      <= 12'sd0;
            x1_r     <= 12'sd0;
            y1_r     <= 12'sd0;
            err_r    <= 12'sd0;
            dx_r     <= 12'sd0;
            dy_r     <= 12'sd0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
            valid_r  <= 1'b0;
        end else if (load) begin
            x_r      <= x0;
            y_r      <= y0;
            x1_r     <= x1;
            y1_r     <= y1;
            dx_r     <= dx_ld_s;
            dy_r     <= dy_ld_s;
            err_r    <= dx_ld_s + dy_ld_s;
            sx_neg_r <= (x1 < x0);
            sy_neg_r <= (y1 < y0);
            valid_r  <= 1'b1;
        end else if (step && valid_r) begin
            if (last_s) begin
                valid_r <= 1'b0;
            end else begin
                x_r   <= x_nxt_s;
                y_r   <= y_nxt_s;
                err_r <= err_nxt_s;
            end
        end
    end

    assign cur_x = x_r;
    assign cur_y = y_r;
    assign valid = valid_r;
    assign last  = last_s;

endmodule

// File: rtl/rope_line_renderer.sv
// Per-player rope renderer: on start, erases the previous rope segment in the
// background colour, then draws the new one from the pivot into the VGA plot port.
module rope_line_renderer
    import rope_line_renderer_pkg::*;
#(
    parameter logic [9:0]       ORIGIN_X = DEFAULT_ORIGIN_X,
    parameter logic [9:0]       ORIGIN_Y = DEFAULT_ORIGIN_Y,
    parameter logic [COL_W-1:0] ROPE_COL = 3'b000,
    parameter logic [COL_W-1:0] BG_COL   = 3'b111
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [9:0]       end_x,
    input  logic [9:0]       end_y,
    output logic [8:0]       vga_x,
    output logic [7:0]       vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             vga_plot,
    output logic             busy,
    output logic             done
);

    localparam coord_t ORG_X_C = coord_t'({2'b00, ORIGIN_X});
    localparam coord_t ORG_Y_C = coord_t'({2'b00, ORIGIN_Y});

    state_t     state_r, next_state_s;
    logic [9:0] new_x_r, new_y_r, prev_x_r, prev_y_r;
    logic       have_prev_r;

    logic       load_s, step_s;
    logic [9:0] tgt_x_s, tgt_y_s;
    coord_t     cur_x_s, cur_y_s;
    logic       stp_valid_s, stp_last_s;

    logic [8:0]       x_nxt_s;
    logic [7:0]       y_nxt_s;
    logic [COL_W-1:0] col_nxt_s;
    logic             plot_nxt_s, busy_nxt_s, done_nxt_s;

    rope_line_stepper u_stepper (
        .clock (clock),
        .reset (reset),
        .load  (load_s),
        .step  (step_s),
        .x0    (ORG_X_C),
        .y0    (ORG_Y_C),
        .x1    (coord_t'({2'b00, tgt_x_s})),
        .y1    (coord_t'({2'b00, tgt_y_s})),
        .cur_x (cur_x_s),
        .cur_y (cur_y_s),
        .valid (stp_valid_s),
        .last  (stp_last_s)
    );

    // Next-state logic and stepper control.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        tgt_x_s      = new_x_r;
        tgt_y_s      = new_y_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (have_prev_r) begin
                        next_state_s = ST_INIT_ERASE;
                    end else begin
                        next_state_s = ST_INIT_DRAW;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INIT_ERASE: begin
                load_s       = 1'b1;
                tgt_x_s      = prev_x_r;
                tgt_y_s      = prev_y_r;
                next_state_s = ST_ERASE;
            end
            ST_ERASE: begin
                step_s = 1'b1;
                if (stp_last_s) begin
                    next_state_s = ST_INIT_DRAW;
                end else begin
                    next_state_s = ST_ERASE;
                end
            end
            ST_INIT_DRAW: begin
                load_s       = 1'b1;
                next_state_s = ST_DRAW;
            end
            ST_DRAW: begin
                step_s = 1'b1;
                if (stp_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAW;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered VGA and handshake outputs.
    always_comb begin
        x_nxt_s    = vga_x;
        y_nxt_s    = vga_y;
        col_nxt_s  = vga_colour;
        plot_nxt_s = 1'b0;
        if ((state_r == ST_ERASE) || (state_r == ST_DRAW)) begin
            x_nxt_s    = cur_x_s[8:0];
            y_nxt_s    = cur_y_s[7:0];
            col_nxt_s  = (state_r == ST_ERASE) ? BG_COL : ROPE_COL;
            // Off-screen pixels still consume a step but are never written.
            plot_nxt_s = stp_valid_s && on_screen(cur_x_s, cur_y_s);
        end else begin
            plot_nxt_s = 1'b0;
        end
        busy_nxt_s = (next_state_s != ST_IDLE);
        done_nxt_s = (state_r == ST_DONE);
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latched endpoints and memory of the rope currently on screen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            new_x_r     <= ORIGIN_X;
            new_y_r     <= ORIGIN_Y;
            prev_x_r    <= ORIGIN_X;
            prev_y_r    <= ORIGIN_Y;
            have_prev_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            new_x_r <= end_x;
            new_y_r <= end_y;
        end else if (state_r == ST_DONE) begin
            prev_x_r    <= new_x_r;
            prev_y_r    <= new_y_r;
            have_prev_r <= 1'b1;
        end
    end

    // Registered outputs so plot, coordinates and colour change together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_x      <= 9'd0;
            vga_y      <= 8'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            vga_x      <= x_nxt_s;
            vga_y      <= y_nxt_s;
            vga_colour <= col_nxt_s;
            vga_plot   <= plot_nxt_s;
            busy       <= busy_nxt_s;
            done       <= done_nxt_s;
        end
    end

endmodule
